rng_stream: RTL and testbench

Parametrised multi-lane xorshift random-number source with seed loading, programmable warm-up and a buffered valid/ready output stream. Successor to the fixed 96-bit seeded generator: width is a multiple of 32, output is decoupled from generation by a FIFO, all-zero lanes are repaired, and generation can be paused. It feeds random words to the stochastic/initialisation datapaths that consume one word per handshake.

---
 rtl/rng_stream.sv | 127 ++++++++++++
 tb/tb_rng_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rng_stream.sv
// Multi-lane xorshift32 random source with seed load, warm-up and a FIFO-buffered
// valid/ready output stream.
//
// state     | meaning
// ST_IDLE   | after reset, lanes zero, waiting for a seed
// ST_WARMUP | stepping lanes every cycle without pushing, busy high
// ST_RUN    | step + push whenever enabled and the FIFO can take a word
module rng_stream #(
  parameter int WIDTH  = 96,
  parameter int DEPTH  = 4,
  parameter int WARMUP = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_seed,
  input  logic [WIDTH-1:0]           seed_in,
  input  logic                       enable,
  output logic                       rnd_valid,
  input  logic                       rnd_ready,
  output logic [WIDTH-1:0]           rnd_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       busy
);

  localparam int LANES = WIDTH / 32;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0] WARM_LAST = (WARMUP > 0) ? CW'(WARMUP - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] lanes, lanes_step;
  logic [CW-1:0]    warm_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic             do_pop, do_push, do_step;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // An all-zero lane is a fixed point of xorshift, so it gets a per-lane constant.
  function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s[32*i +: 32] == 32'd0) r[32*i +: 32] = 32'h6D2B79F5 ^ 32'(i);
      else                        r[32*i +: 32] = s[32*i +: 32];
    end
    return r;
  endfunction

  always_comb begin
    lanes_step = '0;
    for (int i = 0; i < LANES; i++)
      lanes_step[32*i +: 32] = xorshift32(lanes[32*i +: 32]);
  end

  always_comb begin
    state_next = state;
    do_pop     = rnd_valid & rnd_ready & ~load_seed;
    do_push    = 1'b0;
    do_step    = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_WARMUP: begin
        do_step = 1'b1;
        if (warm_cnt == WARM_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        do_push = enable & ((level < LW'(DEPTH)) | do_pop);
        do_step = do_push;
      end
      default: state_next = ST_IDLE;
    endcase
    if (load_seed) begin
      state_next = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
      do_push    = 1'b0;
      do_step    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes    <= '0;
      warm_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load_seed) begin
      lanes    <= seed_fix(seed_in);
      warm_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else begin
      if (do_step) lanes <= lanes_step;
      if (state == ST_WARMUP) warm_cnt <= warm_cnt + CW'(1);
      if (do_push) begin
        mem[wr_ptr] <= lanes_step;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (!do_push && do_pop) level <= level - LW'(1);
    end
  end

  assign rnd_valid  = (level != '0);
  assign rnd_data   = mem[rd_ptr];
  assign fifo_level = level;
  assign busy       = (state == ST_WARMUP);

endmodule

// File: tb/tb_rng_stream.sv
// Scoreboard bench: instance a (no warm-up) and instance b (8-step warm-up)
// compared against a lane-wise xorshift32 sequence model.
module tb_rng_stream;

  logic        clk, rst;
  logic        a_load, a_en, a_valid, a_ready, a_busy;
  logic [95:0] a_seed, a_data;
  logic [2:0]  a_level;
  logic        b_load, b_en, b_valid, b_ready, b_busy;
  logic [95:0] b_seed, b_data;
  logic [2:0]  b_level;

  logic [95:0] q_a[$];
  logic [95:0] q_b[$];
  int checks = 0, errors = 0;
  int pops_a = 0, pops_b = 0, zero_words = 0;

  rng_stream #(.WIDTH(96), .DEPTH(4), .WARMUP(0)) dut_a (
    .clk(clk), .rst(rst), .load_seed(a_load), .seed_in(a_seed), .enable(a_en),
    .rnd_valid(a_valid), .rnd_ready(a_ready), .rnd_data(a_data),
    .fifo_level(a_level), .busy(a_busy));

  rng_stream #(.WIDTH(96), .DEPTH(4), .WARMUP(8)) dut_b (
    .clk(clk), .rst(rst), .load_seed(b_load), .seed_in(b_seed), .enable(b_en),
    .rnd_valid(b_valid), .rnd_ready(b_ready), .rnd_data(b_data),
    .fifo_level(b_level), .busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Expected output stream of one instance after a seed load.
  task automatic fill(input bit sel, input logic [95:0] seed, input int wu);
    logic [31:0] l [3];
    logic [95:0] w;
    for (int i = 0; i < 3; i++) begin
      l[i] = seed[32*i +: 32];
      if (l[i] == 32'd0) l[i] = 32'h6D2B79F5 ^ 32'(i);
    end
    repeat (wu) for (int i = 0; i < 3; i++) l[i] = xs(l[i]);
    if (sel) q_b.delete(); else q_a.delete();
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < 3; i++) begin
        l[i] = xs(l[i]);
        w[32*i +: 32] = l[i];
      end
      if (sel) q_b.push_back(w); else q_a.push_back(w);
    end
  endtask

  task automatic load_a(input logic [95:0] seed);
    a_seed = seed;
    a_load = 1'b1;
    fill(1'b0, seed, 0);
    @(posedge clk); #1;
    a_load = 1'b0;
  endtask

  task automatic load_b(input logic [95:0] seed);
    b_seed = seed;
    b_load = 1'b1;
    fill(1'b1, seed, 8);
    @(posedge clk); #1;
    b_load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (a_valid && a_ready && !a_load) begin
        if (q_a.size() == 0) chk("a_stream_underflow", a_data, 96'd0 - 96'd1);
        else begin
          chk("a_stream", a_data, q_a.pop_front());
          pops_a++;
          if (a_data == 96'd0) zero_words++;
        end
      end
      if (b_valid && b_ready && !b_load) begin
        if (q_b.size() == 0) chk("b_stream_underflow", b_data, 96'd0 - 96'd1);
        else begin
          chk("b_stream", b_data, q_b.pop_front());
          pops_b++;
        end
      end
    end
  end

  initial begin
    logic [95:0] hold;
    logic [31:0] v;
    int bcnt;
    rst = 1'b0;
    a_load = 0; a_en = 0; a_ready = 0; a_seed = '0;
    b_load = 0; b_en = 0; b_ready = 0; b_seed = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {95'd0, a_valid}, 96'd0);
    chk("reset_data", a_data, 96'd0);
    chk("reset_level", {93'd0, a_level}, 96'd0);
    chk("reset_busy", {95'd0, b_busy}, 96'd0);
    rst = 1'b1;
    a_en = 1; b_en = 1; a_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_no_output", {94'd0, a_valid, b_valid}, 96'd0);

    // Known seed, no warm-up
    load_a({32'd3, 32'd2, 32'd1});
    @(posedge clk); #1;
    chk("first_valid", {95'd0, a_valid}, 96'd1);
    chk("first_lane0", {64'd0, a_data[31:0]}, {64'd0, 32'h00042021});
    repeat (64) @(posedge clk);
    #1;

    // Zero seed repair
    load_a(96'd0);
    @(posedge clk); #1;
    chk("zero_seed_lane1", {64'd0, a_data[63:32]}, {64'd0, xs(32'h6D2B79F4)});
    repeat (1000) @(posedge clk);
    #1;

    // Back-pressure then random ready/enable
    a_ready = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("bp_level", {93'd0, a_level}, 96'd4);
    hold = a_data;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_stable", a_data, hold);
    chk("bp_level_hold", {93'd0, a_level}, 96'd4);
    for (int c = 0; c < 300; c++) begin
      a_ready = 1'($urandom_range(0, 1));
      a_en = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    a_en = 1;

    // Reseed with a full FIFO and a pop in the same cycle
    a_ready = 0;
    repeat (8) @(posedge clk);
    #1;
    a_ready = 1;
    load_a({$urandom, $urandom, $urandom});
    chk("reseed_valid_low", {95'd0, a_valid}, 96'd0);
    chk("reseed_level_zero", {93'd0, a_level}, 96'd0);
    repeat (40) @(posedge clk);
    #1;

    // Warm-up: enable low during warm-up, busy for exactly 8 cycles
    b_en = 0; b_ready = 1;
    load_b({32'd1, 32'd1, 32'd1});
    bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (b_busy) bcnt++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", 96'(bcnt), 96'd8);
    chk("warm_no_push_disabled", {95'd0, b_valid}, 96'd0);
    b_en = 1;
    @(posedge clk); #1;
    v = 32'd1;
    repeat (9) v = xs(v);
    chk("warm_first_lane0", {64'd0, b_data[31:0]}, {64'd0, v});
    repeat (30) @(posedge clk);
    #1;

    // Warm-up latency: first word after edge t+9
    load_b({$urandom, $urandom, $urandom});
    for (int j = 0; j <= 9; j++) begin
      chk($sformatf("warm_valid_t%0d", j), {95'd0, b_valid}, {95'd0, (j == 9)});
      if (j < 9) begin
        @(posedge clk); #1;
      end
    end
    repeat (20) @(posedge clk);
    #1;

    // Async reset between edges while running
    #2;
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    chk("areset_valid", {94'd0, a_valid, b_valid}, 96'd0);
    chk("areset_data", a_data | b_data, 96'd0);
    chk("areset_level", {90'd0, a_level, b_level}, 96'd0);
    chk("areset_busy", {95'd0, b_busy}, 96'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_idle", {94'd0, a_valid, b_valid}, 96'd0);

    chk("a_words_seen", 96'(pops_a >= 1100), 96'd1);
    chk("b_words_seen", 96'(pops_b >= 40), 96'd1);
    chk("no_zero_words", 96'(zero_words), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
